// File: rtl/memory_types_pkg.sv
// rtl/memory_types_pkg.sv - shared memory packet and arbiter state types
package memory_types_pkg;

   typedef enum logic [1:0] {
      MEM_READ  = 2'd0,
      MEM_WRITE = 2'd1
   } mem_type_t;

   typedef struct packed {
      mem_type_t   mtype;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [31:0] data;
   } mem_pkt_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_WAIT,
      ARB_RESP
   } arb_state_t;

   // Request-shadow image of an issued packet: command fields kept, payload cleared
   function automatic mem_pkt_t strip_data(input mem_pkt_t p);
      mem_pkt_t r;
      r      = p;
      r.data = '0;
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin / fixed-priority picker
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          rr_en,
   output logic [N-1:0]  grant_oh,
   output logic [IW-1:0] grant_idx,
   output logic          any
);

   logic [IW:0] base;
   logic [IW:0] pos;

   // Scan from the highest offset down so the first requester at/after base wins
   always_comb begin
      grant_idx = '0;
      grant_oh  = '0;
      any       = 1'b0;
      base      = rr_en ? {1'b0, ptr} : '0;
      pos       = '0;
      for (int i = N - 1; i >= 0; i--) begin
         pos = base + (IW + 1)'(i);
         if (pos >= (IW + 1)'(N)) begin
            pos = pos - (IW + 1)'(N);
         end
         if (req[pos[IW-1:0]]) begin
            grant_idx = pos[IW-1:0];
            any       = 1'b1;
         end
      end
      if (any) begin
         grant_oh[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between requesters, one transaction in flight
module mem_arbiter
   import memory_types_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int RR_EN   = 1,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_vld,
   output logic [NUM_REQ-1:0] req_rdy,
   input  mem_pkt_t           req_pkt [NUM_REQ],
   output logic [NUM_REQ-1:0] rsp_vld,
   input  logic [NUM_REQ-1:0] rsp_rdy,
   output mem_pkt_t           rsp_pkt,
   output logic               rsp_err,
   output logic               mem_req_vld,
   input  logic               mem_req_rdy,
   output mem_pkt_t           mem_req_pkt,
   input  logic               mem_rsp_vld,
   output logic               mem_rsp_rdy,
   input  mem_pkt_t           mem_rsp_pkt,
   output logic               err_spur
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   arb_state_t         state_q, state_d;
   logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]      owner_q, owner_d;
   logic [CW-1:0]      wait_cnt_q, wait_cnt_d;
   logic [NUM_REQ-1:0] rsp_vld_q, rsp_vld_d;
   logic               rsp_err_q, rsp_err_d;
   mem_pkt_t           rsp_pkt_q, rsp_pkt_d;
   mem_pkt_t           shadow_q, shadow_d;
   logic               err_spur_q, err_spur_d;

   logic [NUM_REQ-1:0] grant_oh;
   logic [IW-1:0]      grant_idx;
   logic               grant_any;
   logic               issue;

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req       (req_vld),
      .ptr       (rr_ptr_q),
      .rr_en     (RR_EN != 0),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx),
      .any       (grant_any)
   );

   // Request path toward memory; only live in IDLE and never while reset is held
   always_comb begin
      mem_req_vld = 1'b0;
      req_rdy     = '0;
      mem_req_pkt = req_pkt[grant_idx];
      if (rst_n && state_q == ARB_IDLE) begin
         mem_req_vld = grant_any;
         req_rdy     = grant_oh & {NUM_REQ{mem_req_rdy}};
      end
      issue = mem_req_vld & mem_req_rdy;
   end

   // Transaction FSM next-state: issue, wait with timeout, hold response until owner acks
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      wait_cnt_d = wait_cnt_q;
      rsp_vld_d  = rsp_vld_q;
      rsp_err_d  = rsp_err_q;
      rsp_pkt_d  = rsp_pkt_q;
      shadow_d   = shadow_q;
      err_spur_d = err_spur_q | (mem_rsp_vld & (state_q != ARB_WAIT));
      case (state_q)
         ARB_IDLE: begin
            if (issue) begin
               owner_d    = grant_idx;
               wait_cnt_d = '0;
               shadow_d   = strip_data(req_pkt[grant_idx]);
               state_d    = ARB_WAIT;
               if (RR_EN != 0) begin
                  rr_ptr_d = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
               end
            end
         end
         ARB_WAIT: begin
            if (mem_rsp_vld) begin
               rsp_pkt_d          = mem_rsp_pkt;
               rsp_err_d          = 1'b0;
               rsp_vld_d          = '0;
               rsp_vld_d[owner_q] = 1'b1;
               state_d            = ARB_RESP;
            end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
               rsp_pkt_d          = shadow_q;
               rsp_err_d          = 1'b1;
               rsp_vld_d          = '0;
               rsp_vld_d[owner_q] = 1'b1;
               state_d            = ARB_RESP;
            end else begin
               wait_cnt_d = wait_cnt_q + CW'(1);
            end
         end
         ARB_RESP: begin
            if (rsp_rdy[owner_q]) begin
               rsp_vld_d = '0;
               state_d   = ARB_IDLE;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ARB_IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         wait_cnt_q <= '0;
         rsp_vld_q  <= '0;
         rsp_err_q  <= 1'b0;
         rsp_pkt_q  <= '0;
         shadow_q   <= '0;
         err_spur_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         wait_cnt_q <= wait_cnt_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_err_q  <= rsp_err_d;
         rsp_pkt_q  <= rsp_pkt_d;
         shadow_q   <= shadow_d;
         err_spur_q <= err_spur_d;
      end
   end

   assign rsp_vld     = rsp_vld_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_pkt     = rsp_pkt_q;
   assign err_spur    = err_spur_q;
   assign mem_rsp_rdy = (state_q == ARB_WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;
   import memory_types_pkg::*;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req_vld = '0;
   mem_pkt_t   req_pkt [2];
   logic [1:0] rsp_rdy = '0;
   logic [1:0] fp_rsp_rdy = '0;
   logic       mem_req_rdy = 1'b0;
   logic       mem_rsp_vld = 1'b0;
   mem_pkt_t   mem_rsp_pkt = '0;

   logic [1:0] req_rdy, rsp_vld, fp_req_rdy, fp_rsp_vld;
   mem_pkt_t   rsp_pkt, mem_req_pkt, fp_rsp_pkt, fp_mem_req_pkt;
   logic       rsp_err, mem_req_vld, mem_rsp_rdy, err_spur;
   logic       fp_rsp_err, fp_mem_req_vld, fp_mem_rsp_rdy, fp_err_spur;

   int vectors = 0;
   int miscompares = 0;
   int model_ptr = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.NUM_REQ(2), .RR_EN(1), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy), .req_pkt(req_pkt),
      .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_pkt(rsp_pkt), .rsp_err(rsp_err),
      .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_pkt(mem_req_pkt),
      .mem_rsp_vld(mem_rsp_vld), .mem_rsp_rdy(mem_rsp_rdy), .mem_rsp_pkt(mem_rsp_pkt),
      .err_spur(err_spur)
   );

   mem_arbiter #(.NUM_REQ(2), .RR_EN(0), .TIMEOUT(TO)) dut_fp (
      .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(fp_req_rdy), .req_pkt(req_pkt),
      .rsp_vld(fp_rsp_vld), .rsp_rdy(fp_rsp_rdy), .rsp_pkt(fp_rsp_pkt), .rsp_err(fp_rsp_err),
      .mem_req_vld(fp_mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_pkt(fp_mem_req_pkt),
      .mem_rsp_vld(mem_rsp_vld), .mem_rsp_rdy(fp_mem_rsp_rdy), .mem_rsp_pkt(mem_rsp_pkt),
      .err_spur(fp_err_spur)
   );

   function automatic mem_pkt_t rand_pkt();
      mem_pkt_t p;
      p.mtype = ($urandom_range(0, 1) == 0) ? MEM_READ : MEM_WRITE;
      p.addr  = $urandom;
      p.len   = 4'($urandom_range(0, 15));
      p.data  = $urandom;
      return p;
   endfunction

   function automatic int rr_pick(input logic [1:0] v, input int ptr);
      for (int k = 0; k < 2; k++) begin
         if (v[(ptr + k) % 2]) return (ptr + k) % 2;
      end
      return -1;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input logic [1:0] vld, input int stall, input int rsp_delay,
                          input int rdy_delay, output int granted);
      mem_pkt_t   p [2];
      mem_pkt_t   exp_pkt, drv_pkt;
      logic       exp_err;
      logic [1:0] oh, fp_oh;
      int         g, gfp;
      p[0] = rand_pkt();
      p[1] = rand_pkt();
      req_pkt[0] = p[0];
      req_pkt[1] = p[1];
      req_vld = vld;
      mem_req_rdy = 1'b0;
      mem_rsp_vld = 1'b0;
      rsp_rdy = '0;
      fp_rsp_rdy = '0;
      g = rr_pick(vld, model_ptr);
      gfp = vld[0] ? 0 : 1;
      oh = 2'b01 << g;
      fp_oh = 2'b01 << gfp;
      granted = g;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         vectors++;
         if (mem_req_vld !== 1'b1 || req_rdy !== 2'b00) begin
            miscompares++;
            $display("FAIL stall_no_accept: mem_req_vld=%b req_rdy=%b want 1/00", mem_req_vld, req_rdy);
         end
         next_cycle();
      end
      mem_req_rdy = 1'b1;
      @(negedge clk);
      vectors++;
      if (req_rdy !== oh || mem_req_pkt !== p[g] || fp_req_rdy !== fp_oh || mem_req_vld !== 1'b1) begin
         miscompares++;
         $display("FAIL accept: req_rdy=%b pkt=%h fp_rdy=%b got, want %b %h %b", req_rdy, mem_req_pkt,
                  fp_req_rdy, oh, p[g], fp_oh);
      end
      next_cycle();
      model_ptr = (g + 1) % 2;
      mem_req_rdy = 1'b0;
      if (rsp_delay < TO) begin
         drv_pkt = rand_pkt();
         exp_pkt = drv_pkt;
         exp_err = 1'b0;
      end else begin
         drv_pkt = rand_pkt();
         exp_pkt = p[g];
         exp_pkt.data = '0;
         exp_err = 1'b1;
      end
      for (int k = 0; k < TO; k++) begin
         mem_rsp_vld = (k == rsp_delay);
         mem_rsp_pkt = (k == rsp_delay) ? drv_pkt : rand_pkt();
         @(negedge clk);
         vectors++;
         if (mem_rsp_rdy !== 1'b1 || rsp_vld !== 2'b00 || mem_req_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_cycle%0d: mem_rsp_rdy=%b rsp_vld=%b mem_req_vld=%b want 1/00/0", k,
                     mem_rsp_rdy, rsp_vld, mem_req_vld);
         end
         next_cycle();
         if (k == rsp_delay) break;
      end
      mem_rsp_vld = 1'b0;
      for (int h = 0; h <= rdy_delay; h++) begin
         rsp_rdy = (h == rdy_delay) ? oh : ~oh;
         fp_rsp_rdy = (h == rdy_delay) ? 2'b11 : 2'b00;
         @(negedge clk);
         vectors++;
         if (rsp_vld !== oh || rsp_pkt !== exp_pkt || rsp_err !== exp_err || fp_rsp_vld !== fp_oh ||
             mem_req_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL resp_hold%0d: rsp_vld=%b pkt=%h err=%b fp_vld=%b mreq=%b want %b %h %b %b 0",
                     h, rsp_vld, rsp_pkt, rsp_err, fp_rsp_vld, mem_req_vld, oh, exp_pkt, exp_err, fp_oh);
         end
         next_cycle();
      end
      rsp_rdy = '0;
      fp_rsp_rdy = '0;
      @(negedge clk);
      vectors++;
      if (rsp_vld !== 2'b00 || mem_rsp_rdy !== 1'b0 || mem_req_vld !== (|vld) || rsp_pkt !== exp_pkt ||
          err_spur !== 1'b0) begin
         miscompares++;
         $display("FAIL after_ack: rsp_vld=%b mem_rsp_rdy=%b mreq=%b pkt=%h spur=%b want 00 0 %b %h 0",
                  rsp_vld, mem_rsp_rdy, mem_req_vld, rsp_pkt, err_spur, |vld, exp_pkt);
      end
      next_cycle();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_vld = 2'b11;
      mem_req_rdy = 1'b1;
      req_pkt[0] = rand_pkt();
      req_pkt[1] = rand_pkt();
      repeat (3) next_cycle();
      @(negedge clk);
      vectors++;
      if (mem_req_vld !== 1'b0 || req_rdy !== 2'b00 || rsp_vld !== 2'b00 || rsp_err !== 1'b0 ||
          err_spur !== 1'b0 || mem_rsp_rdy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: mreq=%b req_rdy=%b rsp_vld=%b err=%b spur=%b mrsp_rdy=%b want all 0",
                  mem_req_vld, req_rdy, rsp_vld, rsp_err, err_spur, mem_rsp_rdy);
      end
      req_vld = '0;
      mem_req_rdy = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      model_ptr = 0;
      next_cycle();
   endtask

   task automatic test_single_read();
      int g;
      mem_pkt_t p;
      p = '0;
      p.mtype = MEM_READ;
      p.addr = 32'h10;
      req_pkt[0] = p;
      req_vld = 2'b01;
      mem_req_rdy = 1'b1;
      @(negedge clk);
      vectors++;
      if (req_rdy !== 2'b01 || mem_req_pkt !== p) begin
         miscompares++;
         $display("FAIL single_accept: req_rdy=%b pkt=%h want 01 %h", req_rdy, mem_req_pkt, p);
      end
      next_cycle();
      req_vld = 2'b00;
      mem_req_rdy = 1'b0;
      mem_rsp_vld = 1'b1;
      mem_rsp_pkt = p;
      mem_rsp_pkt.data = 32'hDEADBEEF;
      next_cycle();
      mem_rsp_vld = 1'b0;
      @(negedge clk);
      vectors++;
      if (rsp_vld !== 2'b01 || rsp_pkt.data !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
         miscompares++;
         $display("FAIL single_resp: rsp_vld=%b data=%h err=%b want 01 deadbeef 0", rsp_vld, rsp_pkt.data,
                  rsp_err);
      end
      rsp_rdy = 2'b01;
      fp_rsp_rdy = 2'b11;
      next_cycle();
      rsp_rdy = '0;
      fp_rsp_rdy = '0;
      model_ptr = 1;
      run_txn(2'b10, 0, 0, 0, g);
   endtask

   task automatic test_round_robin();
      int g, prev;
      prev = -1;
      for (int i = 0; i < 6; i++) begin
         run_txn(2'b11, 0, 0, 0, g);
         vectors++;
         if (g == prev) begin
            miscompares++;
            $display("FAIL rr_alternate: grant %0d twice in a row", g);
         end
         prev = g;
      end
   endtask

   task automatic test_backpressure();
      int g;
      run_txn(2'b11, 0, 0, 5, g);
      run_txn(2'b01, 0, 2, 5, g);
   endtask

   task automatic test_timeout();
      int g;
      run_txn(2'b01, 0, TO - 1, 0, g);
      run_txn(2'b10, 0, 100, 1, g);
      run_txn(2'b11, 0, TO, 0, g);
   endtask

   task automatic test_no_handshake();
      int g;
      for (int i = 0; i < 3; i++) begin
         req_vld = 2'($urandom_range(1, 3));
         mem_req_rdy = 1'b0;
         @(negedge clk);
         vectors++;
         if (mem_req_vld !== 1'b1 || req_rdy !== 2'b00) begin
            miscompares++;
            $display("FAIL no_rdy: mreq=%b req_rdy=%b want 1 00", mem_req_vld, req_rdy);
         end
         next_cycle();
      end
      req_vld = 2'b00;
      mem_req_rdy = 1'b1;
      repeat (2) begin
         @(negedge clk);
         vectors++;
         if (mem_req_vld !== 1'b0 || req_rdy !== 2'b00 || mem_rsp_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL no_vld: mreq=%b req_rdy=%b mrsp_rdy=%b want 0 00 0", mem_req_vld, req_rdy,
                     mem_rsp_rdy);
         end
         next_cycle();
      end
      run_txn(2'b11, 2, 0, 0, g);
   endtask

   task automatic test_random();
      int g, d;
      for (int i = 0; i < 30; i++) begin
         d = ($urandom_range(0, 7) == 0) ? TO + 4 : $urandom_range(0, 3);
         run_txn(2'($urandom_range(1, 3)), $urandom_range(0, 2), d, $urandom_range(0, 3), g);
      end
   endtask

   task automatic test_spurious();
      req_vld = 2'b00;
      mem_rsp_vld = 1'b1;
      mem_rsp_pkt = rand_pkt();
      next_cycle();
      mem_rsp_vld = 1'b0;
      @(negedge clk);
      vectors++;
      if (err_spur !== 1'b1 || rsp_vld !== 2'b00 || mem_rsp_rdy !== 1'b0) begin
         miscompares++;
         $display("FAIL spur_set: spur=%b rsp_vld=%b mrsp_rdy=%b want 1 00 0", err_spur, rsp_vld, mem_rsp_rdy);
      end
      next_cycle();
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      model_ptr = 0;
      @(negedge clk);
      vectors++;
      if (err_spur !== 1'b0) begin
         miscompares++;
         $display("FAIL spur_clear: spur=%b want 0", err_spur);
      end
      next_cycle();
   endtask

   task automatic test_reset_in_wait();
      int g;
      req_pkt[0] = rand_pkt();
      req_vld = 2'b01;
      mem_req_rdy = 1'b1;
      next_cycle();
      req_vld = 2'b00;
      mem_req_rdy = 1'b0;
      @(negedge clk);
      vectors++;
      if (mem_rsp_rdy !== 1'b1) begin
         miscompares++;
         $display("FAIL enter_wait: mem_rsp_rdy=%b want 1", mem_rsp_rdy);
      end
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      model_ptr = 0;
      @(negedge clk);
      vectors++;
      if (mem_rsp_rdy !== 1'b0 || rsp_vld !== 2'b00 || err_spur !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_wait: mrsp_rdy=%b rsp_vld=%b spur=%b want 0 00 0", mem_rsp_rdy, rsp_vld, err_spur);
      end
      mem_rsp_vld = 1'b1;
      mem_rsp_pkt = rand_pkt();
      next_cycle();
      mem_rsp_vld = 1'b0;
      @(negedge clk);
      vectors++;
      if (err_spur !== 1'b1 || rsp_vld !== 2'b00) begin
         miscompares++;
         $display("FAIL late_rsp: spur=%b rsp_vld=%b want 1 00", err_spur, rsp_vld);
      end
      next_cycle();
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      run_txn(2'b11, 0, 0, 0, g);
   endtask

   initial begin
      req_pkt[0] = '0;
      req_pkt[1] = '0;
      test_reset();
      test_single_read();
      test_round_robin();
      test_backpressure();
      test_timeout();
      test_no_handshake();
      test_random();
      test_spurious();
      test_reset_in_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

endmodule
